// File: rtl/axi_lite_rd_arbiter_if.sv
// Read-side bus bundle for axi_lite_rd_arbiter: per-master AR/R channels plus the shared slave AR/R channels.
// Handshake rule for every channel: a beat transfers on a rising clk edge where valid && ready; a source holds valid and payload stable until that edge.
interface axi_lite_rd_arbiter_if #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32
);
  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0] m_araddr_i;
  logic [NUM_MASTERS-1:0]                 m_arvalid_i;
  logic [NUM_MASTERS-1:0]                 m_arready_o;
  logic [DATA_WIDTH-1:0]                  m_rdata_o;
  logic [NUM_MASTERS-1:0]                 m_rvalid_o;
  logic [NUM_MASTERS-1:0]                 m_rready_i;
  logic [ADDR_WIDTH-1:0]                  s_araddr_o;
  logic                                   s_arvalid_o;
  logic                                   s_arready_i;
  logic [DATA_WIDTH-1:0]                  s_rdata_i;
  logic                                   s_rvalid_i;
  logic                                   s_rready_o;

  // The arbiter side.
  modport master (
    input  m_araddr_i, m_arvalid_i, m_rready_i, s_arready_i, s_rdata_i, s_rvalid_i,
    output m_arready_o, m_rdata_o, m_rvalid_o, s_araddr_o, s_arvalid_o, s_rready_o
  );

  // The environment side: requesting units and the DRAM slave.
  modport slave (
    output m_araddr_i, m_arvalid_i, m_rready_i, s_arready_i, s_rdata_i, s_rvalid_i,
    input  m_arready_o, m_rdata_o, m_rvalid_o, s_araddr_o, s_arvalid_o, s_rready_o
  );
endinterface

// File: rtl/axi_lite_rd_arbiter.sv
// Shares one AXI-lite read port between NUM_MASTERS requesters, one transaction in flight at a time.
// Define AXI_LITE_RD_ARBITER_RR_EN for round-robin arbitration; otherwise the lowest requesting index wins.
module axi_lite_rd_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  axi_lite_rd_arbiter_if.master          bus,
  output logic [NUM_MASTERS-1:0]         grant_o,
  output logic                           busy_o,
  output logic [1:0]                     dbg_state_o,
  output logic [$clog2(NUM_MASTERS)-1:0] dbg_ptr_o
);
  localparam int IW = $clog2(NUM_MASTERS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_e;

  state_e                 state_q;
  logic [IW-1:0]          g_q;
  logic [IW-1:0]          ptr_q;
  logic [NUM_MASTERS-1:0] grant_q;
  logic                   busy_q;
  logic [IW-1:0]          win;

  function automatic logic [IW-1:0] lowest(input logic [NUM_MASTERS-1:0] v);
    lowest = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (v[i]) lowest = IW'(i);
    end
  endfunction

`ifdef AXI_LITE_RD_ARBITER_RR_EN
  logic [NUM_MASTERS-1:0] above_ptr;
  logic [NUM_MASTERS-1:0] req_hi;

  // Requests above the last winner take precedence; otherwise wrap to the lowest index.
  always_comb begin
    above_ptr = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      above_ptr[i] = (IW'(i) > ptr_q);
    end
  end

  assign req_hi = bus.m_arvalid_i & above_ptr;
  assign win    = (|req_hi) ? lowest(req_hi) : lowest(bus.m_arvalid_i);
`else
  assign win = lowest(bus.m_arvalid_i);
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      g_q     <= '0;
      ptr_q   <= IW'(NUM_MASTERS - 1);
      grant_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|bus.m_arvalid_i) begin
            g_q     <= win;
            grant_q <= {{(NUM_MASTERS-1){1'b0}}, 1'b1} << win;
            busy_q  <= 1'b1;
            state_q <= ADDR;
          end
        end
        ADDR: begin
          if (bus.s_arvalid_o && bus.s_arready_i) state_q <= DATA;
        end
        DATA: begin
          if (bus.s_rvalid_i && bus.s_rready_o) begin
            ptr_q   <= g_q;
            grant_q <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          grant_q <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Channel steering is combinational so the granted master sees the slave with no added latency.
  always_comb begin
    bus.m_arready_o = '0;
    bus.m_rvalid_o  = '0;
    bus.s_araddr_o  = '0;
    bus.s_arvalid_o = 1'b0;
    bus.s_rready_o  = 1'b0;
    case (state_q)
      ADDR: begin
        bus.s_araddr_o       = bus.m_araddr_i[g_q];
        bus.s_arvalid_o      = bus.m_arvalid_i[g_q];
        bus.m_arready_o[g_q] = bus.s_arready_i;
      end
      DATA: begin
        bus.m_rvalid_o[g_q] = bus.s_rvalid_i;
        bus.s_rready_o      = bus.m_rready_i[g_q];
      end
      default: ;
    endcase
  end

  assign bus.m_rdata_o = bus.s_rdata_i;
  assign grant_o       = grant_q;
  assign busy_o        = busy_q;
  assign dbg_state_o   = state_q;
  assign dbg_ptr_o     = ptr_q;
endmodule

// File: tb/tb_axi_lite_rd_arbiter.sv
// Bench for axi_lite_rd_arbiter: vector table, directed multi-cycle sequences, then random traffic against a transaction-level model.
// Build with AXI_LITE_RD_ARBITER_RR_EN defined to check the round-robin variant.
module tb_axi_lite_rd_arbiter;
  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = $clog2(N);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [AW-1:0] A0 = 32'h1000_0000;
  localparam logic [AW-1:0] A1 = 32'h2000_0004;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_lite_rd_arbiter_if #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  logic [N-1:0]  grant;
  logic          busy;
  logic [1:0]    dbg_state;
  logic [IW-1:0] dbg_ptr;

  axi_lite_rd_arbiter #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .bus        (bus),
    .grant_o    (grant),
    .busy_o     (busy),
    .dbg_state_o(dbg_state),
    .dbg_ptr_o  (dbg_ptr)
  );

  int checks = 0;
  int errors = 0;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test required finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks / helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic [N-1:0] arv, input logic sarr, input logic srv,
                        input logic [N-1:0] rr);
    bus.m_arvalid_i = arv;
    bus.s_arready_i = sarr;
    bus.s_rvalid_i  = srv;
    bus.m_rready_i  = rr;
  endtask

  // {grant, busy, s_arvalid, s_araddr, m_arready, m_rvalid, s_rready}
  function automatic logic [40:0] obs();
    return {grant, busy, bus.s_arvalid_o, bus.s_araddr_o, bus.m_arready_o,
            bus.m_rvalid_o, bus.s_rready_o};
  endfunction

  // Called just after a negedge; returns at negedge+1 with m_arready_o[idx] high.
  task automatic wait_arr(input int idx, input string name);
    int n = 0;
    #1;
    while (!bus.m_arready_o[idx] && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(name, 64'(n < 20), 64'd1);
  endtask

  function automatic int pick(input logic [N-1:0] v, input int p);
`ifdef AXI_LITE_RD_ARBITER_RR_EN
    for (int k = 1; k <= N; k++) begin
      int idx = (p + k) % N;
      if (v[idx]) return idx;
    end
`else
    for (int i = 0; i < N; i++) begin
      if (v[i]) return i;
    end
`endif
    return -1;
  endfunction

  typedef struct {
    logic [N-1:0]  arv;
    logic          sarr;
    logic          srv;
    logic [N-1:0]  rr;
    logic [N-1:0]  e_grant;
    logic          e_busy;
    logic          e_sarv;
    logic [AW-1:0] e_addr;
    logic [N-1:0]  e_arr;
    logic [N-1:0]  e_rv;
    logic          e_srr;
  } vec_t;

  vec_t vecs[11];
  logic [DW-1:0] rd;
  int got_q[$];
  int want_q[$];
  logic [DW+7:0] exp_q[$];

  // ---------------- stimulus ----------------
  initial begin
    int n;
    logic arr1_seen;
    int owner;
    logic in_data;
    int ptr;
    logic [N-1:0] req;
    logic [AW-1:0] addr [N];
    logic sarr, srv;
    logic [N-1:0] rr;
    logic [N-1:0] e_grant, e_arr, e_rv;
    logic e_busy, e_sarv, e_srr;
    logic [AW-1:0] e_addr;
    logic [DW+7:0] sb;
    int obs_idx;

    //            arv    sarr  srv   rr      grant  busy  sarv  addr   arr    rv     srr
    vecs[0]  = '{2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0, 2'b00, 2'b00, 1'b0};
    vecs[1]  = '{2'b11, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0, 2'b00, 2'b00, 1'b0};
    vecs[2]  = '{2'b11, 1'b0, 1'b0, 2'b00, 2'b01, 1'b1, 1'b1, A0,    2'b00, 2'b00, 1'b0};
    vecs[3]  = '{2'b11, 1'b1, 1'b0, 2'b00, 2'b01, 1'b1, 1'b1, A0,    2'b01, 2'b00, 1'b0};
    vecs[4]  = '{2'b10, 1'b0, 1'b1, 2'b00, 2'b01, 1'b1, 1'b0, 32'h0, 2'b00, 2'b01, 1'b0};
    vecs[5]  = '{2'b10, 1'b0, 1'b1, 2'b01, 2'b01, 1'b1, 1'b0, 32'h0, 2'b00, 2'b01, 1'b1};
    vecs[6]  = '{2'b10, 1'b0, 1'b1, 2'b11, 2'b00, 1'b0, 1'b0, 32'h0, 2'b00, 2'b00, 1'b0};
    vecs[7]  = '{2'b00, 1'b1, 1'b0, 2'b00, 2'b10, 1'b1, 1'b0, A1,    2'b10, 2'b00, 1'b0};
    vecs[8]  = '{2'b10, 1'b1, 1'b0, 2'b00, 2'b10, 1'b1, 1'b1, A1,    2'b10, 2'b00, 1'b0};
    vecs[9]  = '{2'b00, 1'b0, 1'b1, 2'b10, 2'b10, 1'b1, 1'b0, 32'h0, 2'b00, 2'b10, 1'b1};
    vecs[10] = '{2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0, 2'b00, 2'b00, 1'b0};

    set_in('0, 1'b0, 1'b0, '0);
    bus.m_araddr_i = '0;
    bus.s_rdata_i  = '0;

    // Reset
    repeat (3) @(negedge clk);
    #1;
    check("reset_outs", 64'(obs()), 64'd0);
    check("reset_state", 64'(dbg_state), 64'(ST_IDLE));
    check("reset_ptr", 64'(dbg_ptr), 64'(N - 1));
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table
    bus.m_araddr_i[0] = A0;
    bus.m_araddr_i[1] = A1;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      set_in(vecs[i].arv, vecs[i].sarr, vecs[i].srv, vecs[i].rr);
      rd = $urandom;
      bus.s_rdata_i = rd;
      #1;
      check($sformatf("vec%0d", i), 64'(obs()),
            64'({vecs[i].e_grant, vecs[i].e_busy, vecs[i].e_sarv, vecs[i].e_addr,
                 vecs[i].e_arr, vecs[i].e_rv, vecs[i].e_srr}));
      check($sformatf("vec%0d_rdata", i), 64'(bus.m_rdata_o), 64'(rd));
    end

    // Single request from master 1, slave AR after 1 cycle, data after 10
    @(negedge clk);
    set_in(2'b10, 1'b0, 1'b0, 2'b00);
    bus.m_araddr_i[1] = 32'h8000_0010;
    n = 0;
    #1;
    while (!bus.s_arvalid_o && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("single_ar_wait", 64'(n < 10), 64'd1);
    check("single_araddr", 64'(bus.s_araddr_o), 64'h8000_0010);
    check("single_grant_addr", 64'(grant), 64'(2'b10));
    @(negedge clk);
    bus.s_arready_i = 1'b1;
    #1;
    check("single_arready", 64'(bus.m_arready_o), 64'(2'b10));
    @(negedge clk);
    set_in(2'b00, 1'b0, 1'b0, 2'b10);
    for (int c = 0; c < 10; c++) begin
      #1;
      check("single_grant_data", 64'(grant), 64'(2'b10));
      check("single_rvalid_low", 64'(bus.m_rvalid_o), 64'd0);
      check("single_state_data", 64'(dbg_state), 64'(ST_DATA));
      @(negedge clk);
    end
    bus.s_rvalid_i = 1'b1;
    bus.s_rdata_i  = 32'hDEAD_BEEF;
    #1;
    check("single_rvalid", 64'(bus.m_rvalid_o), 64'(2'b10));
    check("single_rdata", 64'(bus.m_rdata_o), 64'hDEAD_BEEF);
    check("single_srready", 64'(bus.s_rready_o), 64'd1);
    @(negedge clk);
    set_in('0, 1'b0, 1'b0, '0);
    #1;
    check("single_idle_outs", 64'(obs()), 64'd0);
    check("single_idle_state", 64'(dbg_state), 64'(ST_IDLE));

    // Both masters request continuously
`ifdef AXI_LITE_RD_ARBITER_RR_EN
    want_q = '{0, 1, 0, 1};
`else
    want_q = '{0, 0, 0};
`endif
    got_q.delete();
    arr1_seen = 1'b0;
    n = 0;
    @(negedge clk);
    set_in(2'b11, 1'b1, 1'b1, 2'b11);
    while (got_q.size() < want_q.size() && n < 100) begin
      #1;
      if (bus.m_arready_o[1]) arr1_seen = 1'b1;
      for (int i = 0; i < N; i++) begin
        if (bus.m_arready_o[i] && bus.m_arvalid_i[i]) got_q.push_back(i);
      end
      @(negedge clk);
      n++;
    end
    check("simul_budget", 64'(n < 100), 64'd1);
    for (int k = 0; k < want_q.size(); k++) begin
      check($sformatf("simul_grant%0d", k), 64'((k < got_q.size()) ? got_q[k] : -1),
            64'(want_q[k]));
    end
`ifndef AXI_LITE_RD_ARBITER_RR_EN
    check("simul_m1_arready", 64'(arr1_seen), 64'd0);
`endif
    bus.m_arvalid_i = '0;
    n = 0;
    #1;
    while (busy && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("simul_drain", 64'(busy), 64'd0);
    @(negedge clk);
    set_in('0, 1'b0, 1'b0, '0);

    // Backpressure on master 0 with master 1 pending
    @(negedge clk);
    set_in(2'b01, 1'b1, 1'b0, 2'b00);
    wait_arr(0, "bp_ar0");
    @(negedge clk);
    set_in(2'b10, 1'b1, 1'b1, 2'b00);
    for (int c = 0; c < 5; c++) begin
      #1;
      check("bp_srready_low", 64'(bus.s_rready_o), 64'd0);
      check("bp_state", 64'(dbg_state), 64'(ST_DATA));
      check("bp_arready_low", 64'(bus.m_arready_o), 64'd0);
      check("bp_rvalid", 64'(bus.m_rvalid_o), 64'(2'b01));
      @(negedge clk);
    end
    bus.m_rready_i = 2'b01;
    #1;
    check("bp_srready_fire", 64'(bus.s_rready_o), 64'd1);
    check("bp_arready_fire", 64'(bus.m_arready_o), 64'd0);
    @(negedge clk);
    bus.m_rready_i = 2'b00;
    bus.s_rvalid_i = 1'b0;
    #1;
    check("bp_idle", 64'(dbg_state), 64'(ST_IDLE));
    check("bp_idle_arready", 64'(bus.m_arready_o), 64'd0);
    @(negedge clk);
    #1;
    check("bp_m1_grant", 64'(grant), 64'(2'b10));
    check("bp_m1_arready", 64'(bus.m_arready_o), 64'(2'b10));
    @(negedge clk);
    set_in(2'b00, 1'b0, 1'b1, 2'b10);
    #1;
    check("bp_m1_rvalid", 64'(bus.m_rvalid_o), 64'(2'b10));
    @(negedge clk);
    set_in('0, 1'b0, 1'b0, '0);
    #1;
    check("bp_done", 64'(busy), 64'd0);

    // Mid-transaction reset: leave pointer at 0 first, then reset while in DATA
    @(negedge clk);
    set_in(2'b01, 1'b1, 1'b0, 2'b00);
    wait_arr(0, "mr_ar_a");
    @(negedge clk);
    set_in(2'b00, 1'b0, 1'b1, 2'b01);
    @(negedge clk);
    set_in('0, 1'b0, 1'b0, '0);
    #1;
    check("mr_ptr_before", 64'(dbg_ptr), 64'd0);
    @(negedge clk);
    set_in(2'b01, 1'b1, 1'b0, 2'b00);
    wait_arr(0, "mr_ar_b");
    @(negedge clk);
    set_in(2'b00, 1'b0, 1'b1, 2'b00);
    #1;
    check("mr_in_data", 64'(dbg_state), 64'(ST_DATA));
    check("mr_rvalid_before", 64'(bus.m_rvalid_o), 64'(2'b01));
    #1;
    rst_n = 1'b0;
    bus.m_rready_i = 2'b01;
    #1;
    check("mr_outs_zero", 64'(obs()), 64'd0);
    check("mr_state", 64'(dbg_state), 64'(ST_IDLE));
    check("mr_ptr_reset", 64'(dbg_ptr), 64'(N - 1));
    @(negedge clk);
    rst_n = 1'b1;
    set_in(2'b11, 1'b0, 1'b0, 2'b00);
    #1;
    check("mr_idle_after", 64'(busy), 64'd0);
    @(negedge clk);
    bus.s_arready_i = 1'b1;
    #1;
    check("mr_first_grant", 64'(grant), 64'(2'b01));
    check("mr_first_arready", 64'(bus.m_arready_o), 64'(2'b01));
    @(negedge clk);
    set_in(2'b00, 1'b0, 1'b1, 2'b01);
    @(negedge clk);
    set_in('0, 1'b0, 1'b0, '0);
    #1;
    check("mr_done", 64'(busy), 64'd0);

    // Random traffic against a transaction-level model
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    owner   = -1;
    in_data = 1'b0;
    ptr     = N - 1;
    req     = '0;
    for (int i = 0; i < N; i++) addr[i] = '0;
    exp_q.delete();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (!req[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            req[i]  = 1'b1;
            addr[i] = $urandom;
          end
        end else if ($urandom_range(0, 31) == 0) begin
          req[i] = 1'b0;
        end
        bus.m_araddr_i[i] = addr[i];
      end
      sarr = 1'($urandom_range(0, 1));
      srv  = ($urandom_range(0, 2) == 0);
      rr   = N'($urandom_range(0, (1 << N) - 1));
      rd   = $urandom;
      set_in(req, sarr, srv, rr);
      bus.s_rdata_i = rd;

      e_grant = '0; e_busy = 1'b0; e_sarv = 1'b0; e_addr = '0;
      e_arr = '0; e_rv = '0; e_srr = 1'b0;
      if (owner >= 0) begin
        e_grant[owner] = 1'b1;
        e_busy = 1'b1;
        if (!in_data) begin
          e_sarv = req[owner];
          e_addr = addr[owner];
          e_arr[owner] = sarr;
        end else begin
          e_rv[owner] = srv;
          e_srr = rr[owner];
          if (srv && rr[owner]) exp_q.push_back({8'(owner), rd});
        end
      end
      #1;
      check("rand_outs", 64'(obs()),
            64'({e_grant, e_busy, e_sarv, e_addr, e_arr, e_rv, e_srr}));
      check("rand_rdata", 64'(bus.m_rdata_o), 64'(rd));

      if (|(bus.m_rvalid_o & bus.m_rready_i)) begin
        obs_idx = 0;
        for (int i = 0; i < N; i++) if (bus.m_rvalid_o[i]) obs_idx = i;
        if (exp_q.size() == 0) begin
          check("rand_unexpected_r", 64'(bus.m_rvalid_o), 64'd0);
        end else begin
          sb = exp_q.pop_front();
          check("rand_r_beat", 64'({8'(obs_idx), bus.m_rdata_o}), 64'(sb));
        end
      end

      if (owner < 0) begin
        if (|req) begin
          owner   = pick(req, ptr);
          in_data = 1'b0;
        end
      end else if (!in_data) begin
        if (req[owner] && sarr) begin
          in_data    = 1'b1;
          req[owner] = 1'b0;
        end
      end else if (srv && rr[owner]) begin
        ptr   = owner;
        owner = -1;
      end
    end
    check("rand_sb_drain", 64'(exp_q.size()), 64'd0);

    @(negedge clk);
    set_in('0, 1'b0, 1'b0, '0);

    // ---------------- final report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
